// File: rtl/sweep_capture.sv
// Captures one detector sample per sweep step into a 512-slot buffer, then
// drains the whole frame in index order over a valid/ready stream.
module sweep_capture #(
  parameter int SAMPLE_W = 12,
  parameter int DEPTH    = 512
) (
  input  logic                CLOCK_IN,
  input  logic                RESET,
  input  logic                ENABLE,
  input  logic [8:0]          INDEX,
  input  logic                FRAME_DONE,
  input  logic [SAMPLE_W-1:0] SAMPLE,
  input  logic                SAMPLE_VALID,
  input  logic                OUT_READY,
  output logic                OUT_VALID,
  output logic [8:0]          OUT_INDEX,
  output logic [SAMPLE_W-1:0] OUT_SAMPLE,
  output logic                BUSY,
  output logic                MISSED,
  output logic                OVERRUN,
  output logic [7:0]          FRAME_COUNT
);
  localparam logic [8:0] LAST_SLOT = 9'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN} state_t;

  state_t              state, state_next;
  logic [8:0]          last_index;
  logic                frame_done_q;
  logic                taken;
  logic [8:0]          rd_ptr;
  logic                issue_done;
  logic [SAMPLE_W-1:0] mem [DEPTH];

  logic step_evt, start_evt, frame_end;
  logic zero_wr, sample_wr, load, beat_last;

  assign step_evt  = (INDEX != last_index);
  assign start_evt = (INDEX == 9'd0) && (last_index != 9'd0);
  assign frame_end = frame_done_q && !FRAME_DONE;

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start_evt && ENABLE) state_next = CAPTURE;
      CAPTURE: if (!ENABLE)             state_next = IDLE;
               else if (frame_end)      state_next = DRAIN;
      DRAIN:   if (beat_last)           state_next = IDLE;
      default:                          state_next = IDLE;
    endcase
  end

  // A step change can close a sample-less step (zero fill of the old slot)
  // and open the new step with a strobe in the same cycle, so mem takes two writes.
  always_comb begin
    zero_wr   = 1'b0;
    sample_wr = 1'b0;
    load      = 1'b0;
    beat_last = 1'b0;
    BUSY      = (state != IDLE);
    if (state == CAPTURE && ENABLE && !RESET) begin
      zero_wr   = step_evt && !taken;
      sample_wr = SAMPLE_VALID && !frame_end && (step_evt || !taken);
    end
    if (state == DRAIN) begin
      load      = !issue_done && (!OUT_VALID || OUT_READY);
      beat_last = OUT_VALID && OUT_READY && (OUT_INDEX == LAST_SLOT);
    end
  end

  always_ff @(posedge CLOCK_IN) begin
    if (RESET) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge CLOCK_IN) begin
    if (zero_wr)   mem[last_index] <= '0;
    if (sample_wr) mem[INDEX]      <= SAMPLE;
  end

  always_ff @(posedge CLOCK_IN) begin
    if (RESET) begin
      last_index   <= '1;
      frame_done_q <= 1'b0;
      taken        <= 1'b0;
      rd_ptr       <= '0;
      issue_done   <= 1'b0;
      OUT_VALID    <= 1'b0;
      OUT_INDEX    <= '0;
      OUT_SAMPLE   <= '0;
      MISSED       <= 1'b0;
      OVERRUN      <= 1'b0;
      FRAME_COUNT  <= '0;
    end else begin
      last_index   <= INDEX;
      frame_done_q <= FRAME_DONE;

      if (state == IDLE && state_next == CAPTURE) begin
        MISSED <= 1'b0;
        taken  <= 1'b0;
      end else if (state == CAPTURE) begin
        taken <= sample_wr || (taken && !step_evt);
      end
      if (zero_wr) MISSED <= 1'b1;

      if (state == CAPTURE && state_next == DRAIN) begin
        rd_ptr     <= '0;
        issue_done <= 1'b0;
      end
      if (state == DRAIN && start_evt) OVERRUN <= 1'b1;

      if (load) begin
        OUT_VALID  <= 1'b1;
        OUT_INDEX  <= rd_ptr;
        OUT_SAMPLE <= mem[rd_ptr];
        rd_ptr     <= rd_ptr + 9'd1;
        if (rd_ptr == LAST_SLOT) issue_done <= 1'b1;
      end else if (OUT_VALID && OUT_READY) begin
        OUT_VALID <= 1'b0;
      end

      if (beat_last) FRAME_COUNT <= FRAME_COUNT + 8'd1;
    end
  end
endmodule

// File: tb/tb_sweep_capture.sv
// Directed bench for sweep_capture: sweeps drive the capture side, a queue
// holds the expected drain beats, a negedge monitor pops and checks them.
module tb_sweep_capture;
  logic        clk = 1'b0;
  logic        RESET, ENABLE, FRAME_DONE, SAMPLE_VALID, OUT_READY;
  logic [8:0]  INDEX;
  logic [11:0] SAMPLE;
  logic        OUT_VALID, BUSY, MISSED, OVERRUN;
  logic [8:0]  OUT_INDEX;
  logic [11:0] OUT_SAMPLE;
  logic [7:0]  FRAME_COUNT;

  sweep_capture #(.SAMPLE_W(12), .DEPTH(512)) dut (
    .CLOCK_IN(clk), .RESET(RESET), .ENABLE(ENABLE), .INDEX(INDEX),
    .FRAME_DONE(FRAME_DONE), .SAMPLE(SAMPLE), .SAMPLE_VALID(SAMPLE_VALID),
    .OUT_READY(OUT_READY), .OUT_VALID(OUT_VALID), .OUT_INDEX(OUT_INDEX),
    .OUT_SAMPLE(OUT_SAMPLE), .BUSY(BUSY), .MISSED(MISSED), .OVERRUN(OVERRUN),
    .FRAME_COUNT(FRAME_COUNT)
  );

  always #5 clk = ~clk;

  typedef struct { logic [8:0] idx; logic [11:0] smp; } beat_t;
  beat_t exp_q[$];

  int checks = 0;
  int passed = 0;
  int cyc = 0;
  int first_beat = -1;
  int last_beat = -1;
  int exp_fc = 0;
  logic        stalled = 1'b0;
  logic [8:0]  st_idx;
  logic [11:0] st_smp;

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
  endtask

  always @(negedge clk) begin
    if (RESET) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        chk("stall_valid", OUT_VALID, 1);
        chk("stall_index", OUT_INDEX, st_idx);
        chk("stall_sample", OUT_SAMPLE, st_smp);
      end
      if (OUT_VALID && OUT_READY) begin
        if (exp_q.size() == 0) begin
          checks++;
          assert (exp_q.size() != 0) passed++;
          else $error("FAIL unexpected_beat: observed index %0d expected no beat", OUT_INDEX);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          chk("beat_index", OUT_INDEX, e.idx);
          chk("beat_sample", OUT_SAMPLE, e.smp);
          if (first_beat < 0) first_beat = cyc;
          last_beat = cyc;
        end
      end
      stalled = OUT_VALID && !OUT_READY;
      st_idx  = OUT_INDEX;
      st_smp  = OUT_SAMPLE;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One sweep 0..511; leaves INDEX at end_idx with FRAME_DONE low, unticked.
  task automatic run_sweep(input int cyc_per, input int miss_idx, input int dbl_idx,
                           input int abort_at, input logic [8:0] end_idx);
    beat_t loc[$];
    for (int i = 0; i < 512; i++) begin
      INDEX      = 9'(i);
      FRAME_DONE = (i == 511);
      if (i == abort_at) begin
        logic seen;
        ENABLE = 1'b0;
        SAMPLE_VALID = 1'b0;
        tick();
        chk("abort_busy", BUSY, 0);
        chk("abort_valid", OUT_VALID, 0);
        seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
          tick();
          seen = seen | OUT_VALID | BUSY;
        end
        chk("abort_quiet", seen, 0);
        chk("abort_frame_count", FRAME_COUNT, exp_fc);
        ENABLE = 1'b1;
        INDEX  = 9'd1;
        FRAME_DONE = 1'b0;
        tick();
        return;
      end
      for (int c = 0; c < cyc_per; c++) begin
        SAMPLE_VALID = 1'b0;
        if (c == 3 && i != miss_idx) begin
          SAMPLE_VALID = 1'b1;
          SAMPLE = (i == dbl_idx) ? 12'd5 : 12'(i * 3);
        end
        if (c == 5 && i == dbl_idx) begin
          SAMPLE_VALID = 1'b1;
          SAMPLE = 12'd9;
        end
        tick();
      end
      SAMPLE_VALID = 1'b0;
      loc.push_back('{idx: 9'(i),
                     smp: (i == miss_idx) ? 12'd0 : (i == dbl_idx) ? 12'd5 : 12'(i * 3)});
    end
    INDEX      = end_idx;
    FRAME_DONE = 1'b0;
    foreach (loc[k]) exp_q.push_back(loc[k]);
  endtask

  // mode 0: ready held high, mode 1: ready random.
  task automatic drain(input int mode, input string tag);
    int  lat;
    logic done;
    lat = -1;
    done = 1'b0;
    first_beat = -1;
    for (int k = 0; k < 4000; k++) begin
      OUT_READY = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      tick();
      if (lat < 0 && OUT_VALID) lat = k + 1;
      if (exp_q.size() == 0 && !OUT_VALID && !BUSY) begin
        done = 1'b1;
        break;
      end
    end
    OUT_READY = 1'b1;
    chk({tag, "_drain_done"}, done, 1);
    chk({tag, "_first_valid_le3"}, (lat > 0 && lat <= 3), 1);
    if (mode == 0) chk({tag, "_no_bubbles"}, last_beat - first_beat, 511);
    exp_fc++;
    chk({tag, "_frame_count"}, FRAME_COUNT, exp_fc);
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    INDEX = 9'd1;
    FRAME_DONE = 1'b0;
    SAMPLE_VALID = 1'b0;
    tick();
    tick();
    RESET = 1'b0;
    exp_q.delete();
    exp_fc = 0;
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: observed no completion expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    RESET = 1'b1; ENABLE = 1'b1; INDEX = 9'd1; FRAME_DONE = 1'b0;
    SAMPLE = '0; SAMPLE_VALID = 1'b0; OUT_READY = 1'b1;
    tick(); tick(); tick();
    chk("rst_out_valid", OUT_VALID, 0);
    chk("rst_out_index", OUT_INDEX, 0);
    chk("rst_out_sample", OUT_SAMPLE, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_missed", MISSED, 0);
    chk("rst_overrun", OVERRUN, 0);
    chk("rst_frame_count", FRAME_COUNT, 0);
    RESET = 1'b0;
    tick();

    // Clean sweep, ready held high.
    run_sweep(20, -1, -1, -1, 9'd1);
    drain(0, "clean");
    chk("clean_missed", MISSED, 0);

    // Missing step 100, double strobe in step 200.
    run_sweep(20, 100, 200, -1, 9'd1);
    drain(0, "gaps");
    chk("gaps_missed", MISSED, 1);

    // Random backpressure; MISSED clears on the new capture.
    run_sweep(8, -1, -1, -1, 9'd1);
    drain(1, "random_ready");
    chk("random_missed", MISSED, 0);

    // Abort at index 300, then a full sweep.
    run_sweep(8, -1, -1, 300, 9'd1);
    run_sweep(8, -1, -1, -1, 9'd1);
    drain(0, "after_abort");

    // Overrun: sweep wraps while the drain is stalled.
    do_reset();
    run_sweep(8, -1, -1, -1, 9'd0);
    OUT_READY = 1'b0;
    tick();
    for (int i = 1; i < 512; i++) begin
      INDEX = 9'(i);
      FRAME_DONE = (i == 511);
      ENABLE = !(i >= 100 && i <= 110);
      for (int c = 0; c < 4; c++) begin
        SAMPLE_VALID = (c == 1);
        SAMPLE = 12'hABC;
        tick();
      end
    end
    SAMPLE_VALID = 1'b0;
    ENABLE = 1'b1;
    INDEX = 9'd0;
    FRAME_DONE = 1'b0;
    tick(); tick();
    chk("ovr_overrun", OVERRUN, 1);
    chk("ovr_busy", BUSY, 1);
    chk("ovr_held_valid", OUT_VALID, 1);
    chk("ovr_held_index", OUT_INDEX, 0);
    INDEX = 9'd1;
    drain(0, "overrun");
    chk("ovr_overrun_sticky", OVERRUN, 1);

    // Reset in the middle of a drain at slot 50.
    run_sweep(8, -1, -1, -1, 9'd1);
    begin
      logic hit;
      hit = 1'b0;
      for (int k = 0; k < 200; k++) begin
        tick();
        if (OUT_VALID && OUT_INDEX == 9'd50) begin
          hit = 1'b1;
          break;
        end
      end
      chk("mid_drain_slot50_reached", hit, 1);
    end
    OUT_READY = 1'b0;
    RESET = 1'b1;
    tick();
    chk("mid_rst_out_valid", OUT_VALID, 0);
    chk("mid_rst_out_index", OUT_INDEX, 0);
    chk("mid_rst_out_sample", OUT_SAMPLE, 0);
    chk("mid_rst_busy", BUSY, 0);
    chk("mid_rst_missed", MISSED, 0);
    chk("mid_rst_overrun", OVERRUN, 0);
    chk("mid_rst_frame_count", FRAME_COUNT, 0);
    RESET = 1'b0;
    OUT_READY = 1'b1;
    exp_q.delete();
    exp_fc = 0;
    tick();
    run_sweep(8, -1, -1, -1, 9'd1);
    drain(0, "post_reset");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
